sa_axis_tile_sender: RTL and testbench

//  AXI-Stream transmitter feeding the systolic array's s_axis_i port.
//  - Holds one P x Q 8-bit tile in a local buffer, loaded through a simple write port.
//  - On start, streams the tile as P*Q beats with tlast on the final beat.
//  - Drives the array's load_control (1 = weight tile, 0 = input tile), latched per transfer.

---
 rtl/sa_axis_tile_sender.sv | 121 ++++++++++++
 tb/tb_sa_axis_tile_sender.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_axis_tile_sender.sv
// sa_axis_tile_sender: holds one P x Q tile and streams it over AXI-Stream
// into the systolic array. It also drives the array's load_control, which is
// latched for each transfer.
// Build option SA_TX_TRANSPOSE_EN: when defined, the tile is streamed in
// column-major order. When it is undefined, the order is row-major.
module sa_axis_tile_sender #(
    parameter int DW = 8,
    parameter int P  = 8,
    parameter int Q  = 8,
    parameter int AW = $clog2(P*Q)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          start_mode,
    output logic          busy,
    output logic          done,
    output logic          load_control,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast
);
    localparam int N = P * Q;

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [N];
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_inc;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_addr;
    logic          hs;
    logic          last_hs;
    logic          start_ok;

    assign hs       = m_axis_tvalid && m_axis_tready;
    assign last_hs  = (state == STREAM) && hs && (cnt == AW'(N - 1));
    // A start that arrives in the done cycle is dropped. Without this rule a
    // back-to-back retrigger could race the array's end-of-tile handling.
    assign start_ok = (state == IDLE) && start && !done;
    assign busy     = (state != IDLE);
    assign cnt_inc  = AW'(cnt + 1'b1);

    // Index of the element to present next: element 0 in FILL, otherwise the
    // element that follows the beat now being handshaken.
    assign rd_idx = (state == FILL) ? '0 : cnt_inc;

`ifdef SA_TX_TRANSPOSE_EN
    // Column-major walk: beat k maps to buffer[(k % P) * Q + k / P].
    assign rd_addr = AW'((int'(rd_idx) % P) * Q + int'(rd_idx) / P);
`else
    assign rd_addr = rd_idx;
`endif

    // Tile buffer. It has no reset, and it is frozen while a transfer runs.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && (int'(wr_addr) < N))
            mem[wr_addr] <= wr_data;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = FILL;
            FILL:    state_nxt = STREAM;
            STREAM:  if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stream datapath: registered tdata/tvalid/tlast, beat counter, done and load_control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            cnt           <= '0;
            done          <= 1'b0;
            load_control  <= 1'b1;
        end else begin
            done <= last_hs;
            if (start_ok) load_control <= start_mode;
            case (state)
                FILL: begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= mem[rd_addr];
                    m_axis_tlast  <= (N == 1);
                    cnt           <= '0;
                end
                STREAM: begin
                    if (hs) begin
                        if (cnt == AW'(N - 1)) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= '0;
                            cnt           <= '0;
                        end else begin
                            cnt          <= cnt_inc;
                            m_axis_tdata <= mem[rd_addr];
                            m_axis_tlast <= (cnt_inc == AW'(N - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_axis_tile_sender.sv
// tb_sa_axis_tile_sender: scoreboard bench for sa_axis_tile_sender.
// When a start is driven, the expected beats are pushed to a queue. The
// monitor pops and compares them as handshakes occur.
module tb_sa_axis_tile_sender;
    localparam int DW = 8, P = 8, Q = 8, N = P * Q, AW = 6;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start, start_mode;
    logic          busy, done, load_control;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

    int            vec_cnt = 0;
    int            err_cnt = 0;
    int            xfer_beats = 0;
    beat_t         exp_q[$];
    logic [DW-1:0] model [N];

    sa_axis_tile_sender #(.DW(DW), .P(P), .Q(Q), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_mode(start_mode), .busy(busy), .done(done),
        .load_control(load_control), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int beat_addr(input int k);
`ifdef SA_TX_TRANSPOSE_EN
        return (k % P) * Q + k / P;
`else
        return k;
`endif
    endfunction

    // Monitor: scoreboard pops on handshakes, stall stability and done pulse checks
    logic          stall_prev = 1'b0;
    logic          hs_last_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev   = 1'b0;
            hs_last_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_tvalid", m_axis_tvalid, 1);
                chk("hold_tdata", m_axis_tdata, prev_data);
                chk("hold_tlast", m_axis_tlast, prev_last);
            end
            if (done || hs_last_prev) chk("done", done, hs_last_prev);
            if (hs_last_prev) chk("busy_fall", busy, 0);
            hs_last_prev = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("tdata", m_axis_tdata, e.data);
                    chk("tlast", m_axis_tlast, e.last);
                    hs_last_prev = e.last;
                end
                xfer_beats++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic load_tile(input int base, input int cnt);
        for (int k = 0; k < cnt; k++) wr(k, DW'(base + k));
    endtask

    // Pulse start. Optionally write the last element in the same cycle. Expected beats are pushed here.
    task automatic start_xfer(input logic mode, input bit rdy0, input bit wr_last, input int base);
        start = 1'b1; start_mode = mode; m_axis_tready = rdy0;
        if (wr_last) begin
            wr_en = 1'b1; wr_addr = AW'(N - 1); wr_data = DW'(base + N - 1);
            model[N-1] = DW'(base + N - 1);
        end
        for (int k = 0; k < N; k++) begin
            beat_t b;
            b.data = model[beat_addr(k)];
            b.last = (k == N - 1);
            exp_q.push_back(b);
        end
        xfer_beats = 0;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        chk("lc_capture", load_control, mode);
        chk("busy_rise", busy, 1);
        chk("tvalid_early", m_axis_tvalid, 0);
        @(posedge clk); #1;
        chk("first_vld_lat", m_axis_tvalid, 1);
    endtask

    // rdy_mode 0: always ready; 1: toggling; 2: 10 stalled cycles, then ready.
    // inj >= 0: at that beat, pulse start and write buffer[5]=FF (both must be ignored).
    task automatic run_xfer(input int rdy_mode, input int inj, input bit start_at_done, input bit chk_bubble);
        int  cyc = 0;
        int  vc = 0;
        bit  fin = 0;
        bit  injd = 0;
        while (!fin && cyc < 1000) begin
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = cyc[0];
                default: begin
                    m_axis_tready = (vc >= 10);
                    if (!m_axis_tready && m_axis_tvalid) vc++;
                end
            endcase
            if (inj >= 0 && !injd && xfer_beats >= inj) begin
                injd = 1; start = 1'b1; start_mode = ~load_control;
                wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hFF;
            end
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            cyc++;
            if (done) fin = 1;
        end
        if (!fin) chk("timeout", 0, 1);
        if (chk_bubble) chk("no_bubble", cyc, N);
        chk("q_empty", exp_q.size(), 0);
        chk("beat_count", xfer_beats, N);
        m_axis_tready = 1'b0;
        if (start_at_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_after", busy, 0);
        chk("no_vld_after", m_axis_tvalid, 0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_mode = 1'b0; m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_lc", load_control, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: base 1, weight mode, ready always; start in the done cycle is ignored
        load_tile(1, N);
        start_xfer(1'b1, 1'b1, 1'b0, 1);
        run_xfer(0, -1, 1'b1, 1'b1);
        chk("lc_t1", load_control, 1);

        // 2: base 10, input mode, toggling ready
        load_tile(10, N);
        start_xfer(1'b0, 1'b0, 1'b0, 10);
        run_xfer(1, -1, 1'b0, 1'b0);
        chk("lc_hold_t2", load_control, 0);

        // 3: start pulse and buffer write mid-transfer are ignored
        load_tile(100, N);
        start_xfer(1'b1, 1'b1, 1'b0, 100);
        run_xfer(0, 20, 1'b0, 1'b0);
        chk("lc_t3", load_control, 1);
        // Re-stream without reloading: buffer[5] must still hold its old value
        start_xfer(1'b0, 1'b1, 1'b0, 100);
        run_xfer(0, -1, 1'b0, 1'b1);

        // 4: asynchronous reset at beat 30, then a full transfer
        load_tile(40, N);
        start_xfer(1'b0, 1'b1, 1'b0, 40);
        begin
            int cyc = 0;
            while (xfer_beats < 30 && cyc < 200) begin
                m_axis_tready = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
            if (xfer_beats < 30) chk("timeout_t4", 0, 1);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tlast", m_axis_tlast, 0);
        chk("arst_done", done, 0);
        chk("arst_lc", load_control, 1);
        exp_q.delete();
        m_axis_tready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", done, 0);
        load_tile(40, N);
        start_xfer(1'b0, 1'b1, 1'b0, 40);
        run_xfer(0, -1, 1'b0, 1'b1);

        // 6: base 1, 10 stalled cycles before the first beat; the last element is written together with start
        load_tile(1, N - 1);
        start_xfer(1'b1, 1'b0, 1'b1, 1);
        run_xfer(2, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
